keypad_encoder: RTL
===================

# keypad_encoder

Upstream front end of the calculator. Scans a 4x4 active-low matrix keypad, debounces it over whole scan frames, and maps each accepted press to the 10-bit button code consumed by `math_calculator_fsm`. Its output is a single-cycle pulse that connects directly to that block's `button` input. Holds, bounces and multi-key chords never produce more than one pulse per physical press.

## Interface
- `SCAN_DIV`, default 1000: clocks per row dwell. Must be at least 4; benches use 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press, and again to accept a release.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `col_n`  in  4  keypad columns, active-low, externally pulled up; asynchronous.
- `row_n`  out  4  row drive, active-low, exactly one row low at a time.
- `button`  out  10  key code, valid for exactly one clock per accepted press; 10'b0 otherwise.
- `key_down`  out  1  level: high from the accepted press until the release is accepted.

## Operation
- **Key map** (row r, column c; index r*4+c):
  - row0: 1 2 3 +
  - row1: 4 5 6 -
  - row2: 7 8 9 *
  - row3: C 0 = /
- **Codes**:
  - digit d in 0..7: {2'b00, 8'b1<<d}
  - 8: 10'b01_0000_0000
  - 9: 10'b01_0000_0001
  - add: 10'b10_0000_0001
  - sub: 10'b10_0000_0010
  - mul: 10'b10_0000_0100
  - div: 10'b10_0000_1000
  - equal: 10'b11_0000_0000
  - clear: 10'b11_1000_0000
  - idle: 10'b0
- **Synchroniser**: `col_n` passes through 2 flip-flops before any use.
- **Scanner**:
  - A dwell counter runs 0..SCAN_DIV-1 for each row.
  - Synchronised columns are sampled on the last dwell cycle into a 16-bit frame snapshot (bit set = key pressed).
  - `row_n` then advances 0→1→2→3→0.
  - A frame completes on the row-3 sample cycle and raises an internal `frame_done` strobe.
- **Frame classification**: exactly one bit set → candidate key; zero bits set → none; two or more bits set → chord.
- **FSM**, evaluated only on `frame_done`:
  - **IDLE**
    - candidate: latch key, stable count=1, go to DEBOUNCE.
    - none or chord: stay in IDLE.
  - **DEBOUNCE**
    - same key: increment count. When count reaches DEBOUNCE_SCANS, go to FIRE.
    - different key: re-latch the new key, count=1.
    - none or chord: go to IDLE.
  - **FIRE**: lasts one clock, independent of `frame_done`. Drives `button`=code of the latched key, sets `key_down`=1, then goes to HELD.
  - **HELD**
    - none: release count=1, go to RELEASE.
    - anything else (same key, other key, chord): stay in HELD. A roll-over never fires.
  - **RELEASE**
    - none: increment count. At DEBOUNCE_SCANS, clear `key_down` and go to IDLE.
    - anything else: go to HELD, count=0.
- **Counter widths**: dwell counter is $clog2(SCAN_DIV) bits; stable/release counters are $clog2(DEBOUNCE_SCANS+1) bits. Counters saturate and never wrap.

## Timing
- **Reset values**: `row_n`=4'b1110, `button`=0, `key_down`=0, FSM=IDLE, dwell counter=0, snapshot=0, all counts=0.
- **Reset mid-press**: the FSM returns to IDLE. A key still held after reset fires after DEBOUNCE_SCANS full frames. No pulse is emitted during reset or in the first clock after it.
- **Frame period**: 4*SCAN_DIV clocks.
- **Press latency**: `button` is high in the clock after the frame_done of the DEBOUNCE_SCANS-th consecutive matching frame.
  - Key already stable at reset release: the first frame_done is at clock 4*SCAN_DIV; the pulse is at clock DEBOUNCE_SCANS*4*SCAN_DIV+1.
- **Release latency**: `key_down` falls in the clock after the DEBOUNCE_SCANS-th consecutive empty frame.
- **Synchroniser delay**: 2 clocks. A column edge reaches the sample only if it arrives at least 2 clocks before the dwell's last cycle.
- **Pulse spacing**: consecutive pulses are at least 2*DEBOUNCE_SCANS frames apart.
- **Registered outputs**: `button` is registered and holds idle (10'b0) whenever the FSM is not in FIRE.

## Structure
- **Package `calc_key_pkg`** holds:
  - the BTN_* 10-bit code localparams, shared with `math_calculator_fsm` and its benches;
  - the FSM state enum;
  - the `key_index_to_code` function (16 entries).
- **Sub-module `keypad_scanner`** owns:
  - the synchroniser and dwell counter;
  - `row_n` rotation;
  - snapshot assembly.
  - It outputs `frame` (16 bits) and `frame_done`.
- **Top-level `keypad_encoder`** holds the debounce FSM and output registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, with a keypad model that pulls `col_n` low when the driven row crosses a pressed key.
- **Clean press**: hold key "5" (row1, col1) from reset release onward → exactly one `button`=10'b00_0010_0000 pulse at clock 33. `key_down` stays high while held; no further pulses.
- **Release and re-press**: release "5", wait 2 empty frames, press "=" → `key_down` falls after the 2nd empty frame. Then exactly one pulse 10'b11_0000_0000.
- **Bounce**: toggle "7" every 3 clocks for 40 clocks, then hold → no pulse during the bounce. Exactly one 10'b00_1000_0000 pulse, 2 frames after the input settles.
- **Chord and roll-over**:
  - Press "+" and "-" together → no pulse.
  - Press "8", then add "9" while "8" is held → one 10'b01_0000_0000 pulse only.
- **Reset mid-press**: assert `rst_n`=0 for 1 clock during HELD on "C" → `button`=0 and `key_down`=0 in the next clock. One 10'b11_1000_0000 pulse after 2 further frames.
- **Full code sweep**: press and release each of the 16 keys in order → each pulse matches the code table, with no other pulses.

Source files
------------

// File: rtl/calc_key_pkg.sv
// Shared calculator key definitions: 10-bit button codes, keypad encoder FSM
// state type and the keypad position-to-code map.
package calc_key_pkg;

   localparam int unsigned CODE_W   = 10;
   localparam int unsigned NUM_KEYS = 16;
   localparam int unsigned KEY_IDX_W = 4;

   localparam logic [CODE_W-1:0] BTN_IDLE  = 10'b00_0000_0000;
   localparam logic [CODE_W-1:0] BTN_0     = 10'b00_0000_0001;
   localparam logic [CODE_W-1:0] BTN_1     = 10'b00_0000_0010;
   localparam logic [CODE_W-1:0] BTN_2     = 10'b00_0000_0100;
   localparam logic [CODE_W-1:0] BTN_3     = 10'b00_0000_1000;
   localparam logic [CODE_W-1:0] BTN_4     = 10'b00_0001_0000;
   localparam logic [CODE_W-1:0] BTN_5     = 10'b00_0010_0000;
   localparam logic [CODE_W-1:0] BTN_6     = 10'b00_0100_0000;
   localparam logic [CODE_W-1:0] BTN_7     = 10'b00_1000_0000;
   localparam logic [CODE_W-1:0] BTN_8     = 10'b01_0000_0000;
   localparam logic [CODE_W-1:0] BTN_9     = 10'b01_0000_0001;
   localparam logic [CODE_W-1:0] BTN_ADD   = 10'b10_0000_0001;
   localparam logic [CODE_W-1:0] BTN_SUB   = 10'b10_0000_0010;
   localparam logic [CODE_W-1:0] BTN_MUL   = 10'b10_0000_0100;
   localparam logic [CODE_W-1:0] BTN_DIV   = 10'b10_0000_1000;
   localparam logic [CODE_W-1:0] BTN_EQUAL = 10'b11_0000_0000;
   localparam logic [CODE_W-1:0] BTN_CLEAR = 10'b11_1000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_FIRE,
      ST_HELD,
      ST_RELEASE
   } key_state_e;

   // Keypad position (row*4 + col) to button code.
   function automatic logic [CODE_W-1:0] key_index_to_code(input logic [KEY_IDX_W-1:0] idx);
      logic [CODE_W-1:0] code;
      case (idx)
         4'd0:    code = BTN_1;
         4'd1:    code = BTN_2;
         4'd2:    code = BTN_3;
         4'd3:    code = BTN_ADD;
         4'd4:    code = BTN_4;
         4'd5:    code = BTN_5;
         4'd6:    code = BTN_6;
         4'd7:    code = BTN_SUB;
         4'd8:    code = BTN_7;
         4'd9:    code = BTN_8;
         4'd10:   code = BTN_9;
         4'd11:   code = BTN_MUL;
         4'd12:   code = BTN_CLEAR;
         4'd13:   code = BTN_0;
         4'd14:   code = BTN_EQUAL;
         default: code = BTN_DIV;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner for a 4x4 active-low keypad. Synchronises the columns, dwells
// SCAN_DIV clocks per row, and assembles a 16-bit pressed-key snapshot.
//   clk, rst_n  : clock, synchronous active-low reset
//   col_n       : asynchronous active-low column inputs
//   row_n       : active-low row drive, one row low at a time
//   frame       : snapshot, bit r*4+c set = key pressed
//   frame_done  : one-clock strobe when frame holds a complete scan
module keypad_scanner
   import calc_key_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          col_n,
   output logic [3:0]          row_n,
   output logic [NUM_KEYS-1:0] frame,
   output logic                frame_done
);

   localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

   logic [3:0]          col_meta;
   logic [3:0]          col_sync;
   logic [DWELL_W-1:0]  dwell;
   logic [1:0]          row_idx;
   logic                dwell_end;

   assign dwell_end = (dwell == DWELL_LAST);

   // Two-flop column synchroniser; idle columns read high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_meta <= 4'hF;
         col_sync <= 4'hF;
      end else begin
         col_meta <= col_n;
         col_sync <= col_meta;
      end
   end

   // Dwell counter, row rotation and snapshot; the row-3 sample closes a frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell      <= '0;
         row_idx    <= 2'd0;
         row_n      <= 4'b1110;
         frame      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (dwell_end) begin
            dwell                        <= '0;
            frame[{row_idx, 2'b00} +: 4] <= ~col_sync;
            row_idx                      <= row_idx + 2'd1;
            row_n                        <= {row_n[2:0], row_n[3]};
            frame_done                   <= (row_idx == 2'd3);
         end else begin
            dwell <= dwell + DWELL_W'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: scans and debounces a 4x4 keypad over whole frames and
// emits a one-clock button code per accepted press.
//   clk, rst_n : clock, synchronous active-low reset
//   col_n      : asynchronous active-low keypad columns
//   row_n      : active-low row drive
//   button     : key code for one clock per press, 0 otherwise
//   key_down   : high from accepted press until accepted release
module keypad_encoder
   import calc_key_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        col_n,
   output logic [3:0]        row_n,
   output logic [CODE_W-1:0] button,
   output logic              key_down
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   logic [NUM_KEYS-1:0]  frame;
   logic                 frame_done;
   logic                 is_none;
   logic                 is_single;
   logic [KEY_IDX_W-1:0] frame_idx;
   logic [KEY_IDX_W-1:0] key_idx;
   logic [CNT_W-1:0]     stable_cnt;
   logic [CNT_W-1:0]     rel_cnt;
   logic [CNT_W-1:0]     stable_inc_c;
   logic [CNT_W-1:0]     rel_inc_c;
   key_state_e           state;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk        (clk),
      .rst_n      (rst_n),
      .col_n      (col_n),
      .row_n      (row_n),
      .frame      (frame),
      .frame_done (frame_done)
   );

   // Frame classification: none, exactly one key, or chord.
   always_comb begin
      is_none   = (frame == '0);
      is_single = !is_none && ((frame & (frame - 16'd1)) == '0);
      frame_idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (frame[i]) frame_idx = KEY_IDX_W'(i);
      end
   end

   // Saturating count increments.
   always_comb begin
      stable_inc_c = (stable_cnt == CNT_DONE) ? stable_cnt : stable_cnt + CNT_ONE;
      rel_inc_c    = (rel_cnt == CNT_DONE) ? rel_cnt : rel_cnt + CNT_ONE;
   end

   // Debounce FSM; button is loaded on entry to FIRE so it is high only there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         key_idx    <= '0;
         stable_cnt <= '0;
         rel_cnt    <= '0;
         button     <= BTN_IDLE;
         key_down   <= 1'b0;
      end else begin
         button <= BTN_IDLE;
         case (state)
            ST_IDLE: begin
               if (frame_done && is_single) begin
                  key_idx    <= frame_idx;
                  stable_cnt <= CNT_ONE;
                  if (CNT_ONE == CNT_DONE) begin
                     state    <= ST_FIRE;
                     button   <= key_index_to_code(frame_idx);
                     key_down <= 1'b1;
                  end else begin
                     state <= ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_done) begin
                  if (!is_single) begin
                     state      <= ST_IDLE;
                     stable_cnt <= '0;
                  end else if (frame_idx != key_idx) begin
                     key_idx    <= frame_idx;
                     stable_cnt <= CNT_ONE;
                  end else begin
                     stable_cnt <= stable_inc_c;
                     if (stable_inc_c == CNT_DONE) begin
                        state    <= ST_FIRE;
                        button   <= key_index_to_code(key_idx);
                        key_down <= 1'b1;
                     end
                  end
               end
            end
            ST_FIRE: begin
               state      <= ST_HELD;
               stable_cnt <= '0;
            end
            ST_HELD: begin
               // Anything but an empty frame (including roll-over) keeps holding.
               if (frame_done && is_none) begin
                  rel_cnt <= CNT_ONE;
                  if (CNT_ONE == CNT_DONE) begin
                     state    <= ST_IDLE;
                     key_down <= 1'b0;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               if (frame_done) begin
                  if (is_none) begin
                     rel_cnt <= rel_inc_c;
                     if (rel_inc_c == CNT_DONE) begin
                        state    <= ST_IDLE;
                        key_down <= 1'b0;
                        rel_cnt  <= '0;
                     end
                  end else begin
                     state   <= ST_HELD;
                     rel_cnt <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
